// File: rtl/nts_ntp_header_parser.sv
// nts_ntp_header_parser
//
// Receive-side NTP header parser for NTS client requests. It takes the 48-byte
// NTP header as six 64-bit big-endian words. The parser checks the version and
// mode from word 0 and captures the client transmit timestamp from word 5.
// After that it waits for the NTS authentication verdict. It then issues the
// record-receive, transmit and clear pulses that nts_timestamp expects.
//
// Ports:
//   i_clk, i_areset            clock; asynchronous active-high reset
//   i_rx_valid/start/data      header word stream (start marks word 0)
//   i_rx_abort                 upstream truncation; drop the current header
//   i_auth_ok, i_auth_fail     NTS authentication verdict (fail wins)
//   o_busy                     a header is in progress
//   o_record_receive_timestamp pulse one cycle after word 0
//   o_transmit, o_clear        mutually exclusive outcome pulses
//   o_origin_timestamp         client transmit timestamp (word 5)
//   o_version_number, o_poll   fields from word 0
//   o_cnt_accepted/rejected    wrapping outcome counters
module nts_ntp_header_parser #(
    parameter int unsigned VN_MIN      = 3,
    parameter int unsigned VN_MAX      = 4,
    parameter int unsigned MODE_CLIENT = 3
) (
    input  logic        i_clk,
    input  logic        i_areset,
    input  logic        i_rx_valid,
    input  logic        i_rx_start,
    input  logic [63:0] i_rx_data,
    input  logic        i_rx_abort,
    input  logic        i_auth_ok,
    input  logic        i_auth_fail,
    output logic        o_busy,
    output logic        o_record_receive_timestamp,
    output logic        o_transmit,
    output logic        o_clear,
    output logic [63:0] o_origin_timestamp,
    output logic [2:0]  o_version_number,
    output logic [7:0]  o_poll,
    output logic [31:0] o_cnt_accepted,
    output logic [31:0] o_cnt_rejected
);

    typedef enum logic [1:0] {StIdle, StHdr, StWaitAuth} state_e;

    localparam logic [2:0] VnMin      = 3'(VN_MIN);
    localparam logic [2:0] VnMax      = 3'(VN_MAX);
    localparam logic [2:0] ModeClient = 3'(MODE_CLIENT);
    localparam logic [2:0] LastWord   = 3'd5;

    state_e      state_q, state_d;
    logic [2:0]  word_cnt_q, word_cnt_d;
    logic        bad_q, bad_d;
    logic [2:0]  vn_q, vn_d;
    logic [7:0]  poll_q, poll_d;
    logic [63:0] origin_q, origin_d;
    logic        record_q, record_d;
    logic        transmit_q, transmit_d;
    logic        clear_q, clear_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] rej_q, rej_d;

    logic       hdr_start;
    logic [2:0] rx_vn;
    logic [2:0] rx_mode;
    logic       rx_bad;

    assign hdr_start = i_rx_valid && i_rx_start;
    assign rx_vn     = i_rx_data[61:59];
    assign rx_mode   = i_rx_data[58:56];
    // The header is judged once, at word 0. The remaining words are still
    // consumed so that the upstream framing stays aligned.
    assign rx_bad    = (rx_vn < VnMin) || (rx_vn > VnMax) || (rx_mode != ModeClient);

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        bad_d      = bad_q;
        vn_d       = vn_q;
        poll_d     = poll_q;
        origin_d   = origin_q;
        record_d   = 1'b0;
        transmit_d = 1'b0;
        clear_d    = 1'b0;
        acc_d      = acc_q;
        rej_d      = rej_q;

        case (state_q)
            StIdle: begin
                if (hdr_start) begin
                    state_d    = StHdr;
                    word_cnt_d = 3'd1;
                    bad_d      = rx_bad;
                    vn_d       = rx_vn;
                    poll_d     = i_rx_data[47:40];
                    record_d   = 1'b1;
                end
            end
            StHdr: begin
                if (i_rx_abort) begin
                    state_d    = StIdle;
                    word_cnt_d = 3'd0;
                    clear_d    = 1'b1;
                    rej_d      = rej_q + 32'd1;
                end else if (hdr_start) begin
                    // A restart drops the old header and begins the new one in the same cycle.
                    word_cnt_d = 3'd1;
                    bad_d      = rx_bad;
                    vn_d       = rx_vn;
                    poll_d     = i_rx_data[47:40];
                    record_d   = 1'b1;
                    clear_d    = 1'b1;
                    rej_d      = rej_q + 32'd1;
                end else if (i_rx_valid) begin
                    if (word_cnt_q == LastWord) begin
                        origin_d   = i_rx_data;
                        word_cnt_d = 3'd0;
                        state_d    = StWaitAuth;
                    end else begin
                        word_cnt_d = word_cnt_q + 3'd1;
                    end
                end
            end
            StWaitAuth: begin
                if (i_rx_abort || bad_q || i_auth_fail) begin
                    state_d = StIdle;
                    clear_d = 1'b1;
                    rej_d   = rej_q + 32'd1;
                end else if (i_auth_ok) begin
                    state_d    = StIdle;
                    transmit_d = 1'b1;
                    acc_d      = acc_q + 32'd1;
                end
            end
            default: begin
                state_d    = StIdle;
                word_cnt_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q    <= StIdle;
            word_cnt_q <= 3'd0;
            bad_q      <= 1'b0;
            vn_q       <= 3'd0;
            poll_q     <= 8'd0;
            origin_q   <= 64'd0;
            record_q   <= 1'b0;
            transmit_q <= 1'b0;
            clear_q    <= 1'b0;
            acc_q      <= 32'd0;
            rej_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            bad_q      <= bad_d;
            vn_q       <= vn_d;
            poll_q     <= poll_d;
            origin_q   <= origin_d;
            record_q   <= record_d;
            transmit_q <= transmit_d;
            clear_q    <= clear_d;
            acc_q      <= acc_d;
            rej_q      <= rej_d;
        end
    end

    assign o_busy                     = (state_q != StIdle);
    assign o_record_receive_timestamp = record_q;
    assign o_transmit                 = transmit_q;
    assign o_clear                    = clear_q;
    assign o_origin_timestamp         = origin_q;
    assign o_version_number           = vn_q;
    assign o_poll                     = poll_q;
    assign o_cnt_accepted             = acc_q;
    assign o_cnt_rejected             = rej_q;

endmodule

// File: tb/tb_nts_ntp_header_parser.sv
// Testbench for nts_ntp_header_parser. Directed header sequences push their
// expected pulse events into a queue. A negedge monitor pops one entry for
// every cycle in which any control pulse is seen and compares the two.
module tb_nts_ntp_header_parser;

    logic        i_clk = 1'b0;
    logic        i_areset = 1'b1;
    logic        i_rx_valid = 1'b0;
    logic        i_rx_start = 1'b0;
    logic [63:0] i_rx_data = 64'd0;
    logic        i_rx_abort = 1'b0;
    logic        i_auth_ok = 1'b0;
    logic        i_auth_fail = 1'b0;
    logic        o_busy;
    logic        o_record_receive_timestamp;
    logic        o_transmit;
    logic        o_clear;
    logic [63:0] o_origin_timestamp;
    logic [2:0]  o_version_number;
    logic [7:0]  o_poll;
    logic [31:0] o_cnt_accepted;
    logic [31:0] o_cnt_rejected;

    nts_ntp_header_parser dut (
        .i_clk                      (i_clk),
        .i_areset                   (i_areset),
        .i_rx_valid                 (i_rx_valid),
        .i_rx_start                 (i_rx_start),
        .i_rx_data                  (i_rx_data),
        .i_rx_abort                 (i_rx_abort),
        .i_auth_ok                  (i_auth_ok),
        .i_auth_fail                (i_auth_fail),
        .o_busy                     (o_busy),
        .o_record_receive_timestamp (o_record_receive_timestamp),
        .o_transmit                 (o_transmit),
        .o_clear                    (o_clear),
        .o_origin_timestamp         (o_origin_timestamp),
        .o_version_number           (o_version_number),
        .o_poll                     (o_poll),
        .o_cnt_accepted             (o_cnt_accepted),
        .o_cnt_rejected             (o_cnt_rejected)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rec;
        logic        tx;
        logic        clr;
        logic [63:0] origin;
        logic [2:0]  vn;
        logic [7:0]  poll;
        logic [31:0] acc;
        logic [31:0] rej;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_acc = 32'd0;
    logic [31:0] exp_rej = 32'd0;

    localparam logic [63:0] W0V4  = 64'h230006EC00000000;
    localparam logic [63:0] W0V3  = 64'h1B0006EC00000000;
    localparam logic [63:0] W0V5  = 64'h2B0006EC00000000;
    localparam logic [63:0] W0M4  = 64'h240006EC00000000;
    localparam logic [63:0] W5    = 64'hFFFFDDDD00000000;
    localparam logic [63:0] W5B   = 64'h0123456789ABCDEF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic rec, input logic tx, input logic clr,
                        input logic [63:0] origin, input logic [2:0] vn, input logic [7:0] poll);
        exp_t e;
        e.rec = rec; e.tx = tx; e.clr = clr;
        e.origin = origin; e.vn = vn; e.poll = poll;
        e.acc = exp_acc; e.rej = exp_rej;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [63:0] data, input logic start);
        i_rx_valid = 1'b1;
        i_rx_start = start;
        i_rx_data  = data;
        tick();
        i_rx_valid = 1'b0;
        i_rx_start = 1'b0;
        i_rx_data  = 64'd0;
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send(64'd0, 1'b0);
    endtask

    task automatic header0(input logic [63:0] w0, input logic [2:0] vn);
        push(1'b1, 1'b0, 1'b0, 64'd0, vn, 8'h06);
        send(w0, 1'b1);
    endtask

    // Full good header followed by i_auth_ok; expects a transmit pulse.
    task automatic good_header(input logic [63:0] w0, input logic [2:0] vn,
                               input logic [63:0] w5);
        header0(w0, vn);
        send_zeros(4);
        send(w5, 1'b0);
        check("busy_wait_auth", 64'(o_busy), 64'd1);
        exp_acc = exp_acc + 32'd1;
        push(1'b0, 1'b1, 1'b0, w5, vn, 8'h06);
        i_auth_ok = 1'b1;
        tick();
        i_auth_ok = 1'b0;
        check("busy_after_tx", 64'(o_busy), 64'd0);
    endtask

    // Header with a bad version or mode: cleared after word 5 without any auth.
    task automatic bad_header(input logic [63:0] w0, input logic [2:0] vn);
        header0(w0, vn);
        send_zeros(4);
        exp_rej = exp_rej + 32'd1;
        push(1'b0, 1'b0, 1'b1, 64'd0, vn, 8'h06);
        send(W5B, 1'b0);
        tick();
        i_auth_ok = 1'b1;
        tick();
        i_auth_ok = 1'b0;
        tick();
        check("busy_after_bad", 64'(o_busy), 64'd0);
    endtask

    // Monitor: one queue entry per cycle with any pulse high.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (!i_areset && (o_record_receive_timestamp || o_transmit || o_clear)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: got rec=%0b tx=%0b clr=%0b expected none",
                             o_record_receive_timestamp, o_transmit, o_clear);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_record", 64'(o_record_receive_timestamp), 64'(e.rec));
                    check("ev_transmit", 64'(o_transmit), 64'(e.tx));
                    check("ev_clear", 64'(o_clear), 64'(e.clr));
                    check("ev_cnt_accepted", 64'(o_cnt_accepted), 64'(e.acc));
                    check("ev_cnt_rejected", 64'(o_cnt_rejected), 64'(e.rej));
                    if (e.tx || e.rec) begin
                        check("ev_version", 64'(o_version_number), 64'(e.vn));
                        check("ev_poll", 64'(o_poll), 64'(e.poll));
                    end
                    if (e.tx) check("ev_origin", o_origin_timestamp, e.origin);
                end
            end
        end
    end

    initial begin
        int budget;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_pulses", 64'({o_record_receive_timestamp, o_transmit, o_clear}), 64'd0);
        check("rst_origin", o_origin_timestamp, 64'd0);
        check("rst_cnt", 64'({o_cnt_accepted, o_cnt_rejected}), 64'd0);
        i_areset = 1'b0;
        tick();

        // Stray word without start is ignored.
        send(64'hDEADBEEF00000000, 1'b0);
        check("stray_busy", 64'(o_busy), 64'd0);

        // Good v4 request; check the record latency directly too.
        header0(W0V4, 3'd4);
        check("record_latency", 64'(o_record_receive_timestamp), 64'd1);
        send_zeros(4);
        send(W5, 1'b0);
        exp_acc = exp_acc + 32'd1;
        push(1'b0, 1'b1, 1'b0, W5, 3'd4, 8'h06);
        i_auth_ok = 1'b1;
        tick();
        i_auth_ok = 1'b0;
        check("v4_transmit", 64'(o_transmit), 64'd1);
        tick();

        // Version 3 accepted, then version 5 and mode 4 rejected.
        good_header(W0V3, 3'd3, W5B);
        bad_header(W0V5, 3'd5);
        bad_header(W0M4, 3'd4);

        // Abort after word 2, with a valid word in the same cycle.
        header0(W0V4, 3'd4);
        send_zeros(2);
        exp_rej = exp_rej + 32'd1;
        push(1'b0, 1'b0, 1'b1, 64'd0, 3'd4, 8'h06);
        i_rx_abort = 1'b1;
        send(64'd0, 1'b0);
        i_rx_abort = 1'b0;
        check("abort_busy", 64'(o_busy), 64'd0);
        tick();
        good_header(W0V4, 3'd4, W5);

        // Auth ok and fail in the same cycle: fail wins.
        header0(W0V4, 3'd4);
        send_zeros(4);
        send(W5, 1'b0);
        exp_rej = exp_rej + 32'd1;
        push(1'b0, 1'b0, 1'b1, 64'd0, 3'd4, 8'h06);
        i_auth_ok = 1'b1;
        i_auth_fail = 1'b1;
        tick();
        i_auth_ok = 1'b0;
        i_auth_fail = 1'b0;
        tick();

        // Restart at word 3: clear and record in the same cycle.
        header0(W0V4, 3'd4);
        send_zeros(2);
        exp_rej = exp_rej + 32'd1;
        push(1'b1, 1'b0, 1'b1, 64'd0, 3'd3, 8'h06);
        send(W0V3, 1'b1);
        send_zeros(4);
        send(W5B, 1'b0);
        exp_acc = exp_acc + 32'd1;
        push(1'b0, 1'b1, 1'b0, W5B, 3'd3, 8'h06);
        i_auth_ok = 1'b1;
        tick();
        i_auth_ok = 1'b0;
        tick();
        check("total_accepted", 64'(o_cnt_accepted), 64'd4);
        check("total_rejected", 64'(o_cnt_rejected), 64'd5);

        // Reset mid-header: everything returns to zero with no pulses.
        header0(W0V4, 3'd4);
        send_zeros(2);
        #2;
        i_areset = 1'b1;
        #1;
        check("midrst_busy", 64'(o_busy), 64'd0);
        check("midrst_pulses", 64'({o_record_receive_timestamp, o_transmit, o_clear}), 64'd0);
        check("midrst_fields", 64'({o_version_number, o_poll}), 64'd0);
        check("midrst_origin", o_origin_timestamp, 64'd0);
        check("midrst_cnt", 64'({o_cnt_accepted, o_cnt_rejected}), 64'd0);
        exp_acc = 32'd0;
        exp_rej = 32'd0;
        tick();
        i_areset = 1'b0;
        send_zeros(3);
        check("post_rst_busy", 64'(o_busy), 64'd0);
        repeat (3) tick();

        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check("pending_events", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nts_ntp_header_parser.md
Name: nts_ntp_header_parser

Overview:
- RX-side counterpart of the timestamp/TX header generator: consumes the 48-byte NTP header of an incoming client request as six 64-bit words.
- Validates version and mode, then extracts the client transmit timestamp, version and poll.
- Drives the record-receive / transmit / clear control pulses and origin-timestamp bus that the timestamp block expects.
- Sits between the RX packet buffer reader and nts_timestamp; the transmit decision is gated by the NTS authentication result.

Parameters:
- VN_MIN, 3, lowest accepted NTP version number.
- VN_MAX, 4, highest accepted NTP version number.
- MODE_CLIENT, 3, only accepted NTP mode.

Ports:
- i_clk  in  1  clock
- i_areset  in  1  reset, asynchronous, active-high
- i_rx_valid  in  1  i_rx_data holds a header word this cycle
- i_rx_start  in  1  qualifies i_rx_valid: word is header word 0
- i_rx_data  in  64  header word, big-endian (bits 63:56 = first byte)
- i_rx_abort  in  1  upstream truncation/error; abandon current header
- i_auth_ok  in  1  NTS authentication passed
- i_auth_fail  in  1  NTS authentication failed
- o_busy  out  1  state != IDLE
- o_record_receive_timestamp  out  1  one-cycle pulse
- o_transmit  out  1  one-cycle pulse
- o_clear  out  1  one-cycle pulse
- o_origin_timestamp  out  64  client transmit timestamp (header word 5)
- o_version_number  out  3  VN from header word 0
- o_poll  out  8  poll from header word 0
- o_cnt_accepted  out  32  headers that reached transmit
- o_cnt_rejected  out  32  headers cleared for any reason

Behaviour:
- Reset: all outputs 0, state IDLE, word counter 0. Reset mid-header abandons it without a clear pulse or counter update.
- States: IDLE, HDR, WAIT_AUTH.
- IDLE:
  - i_rx_valid & i_rx_start -> HDR, counter = 1.
  - Latch VN = data[61:59], mode = data[58:56], poll = data[47:40].
  - o_record_receive_timestamp = 1 the next cycle, registered, so latency is 1.
  - Valid words without start are ignored.
- HDR:
  - Each i_rx_valid word increments the counter.
  - At counter == 5, latch data into o_origin_timestamp and go to WAIT_AUTH.
  - Words 1..4 are discarded.
- Validation: computed at the word-0 latch. If VN is outside [VN_MIN, VN_MAX] or mode != MODE_CLIENT, the header is marked bad; words are still consumed through word 5.
- WAIT_AUTH:
  - Bad header: on entry, pulse o_clear, increment o_cnt_rejected, go to IDLE. Auth inputs are ignored.
  - Good header + i_auth_ok: pulse o_transmit, increment o_cnt_accepted, go to IDLE.
  - Good header + i_auth_fail: pulse o_clear, increment o_cnt_rejected, go to IDLE.
  - i_auth_ok and i_auth_fail together: fail wins.
- Output hold: o_version_number, o_poll and o_origin_timestamp are valid while o_transmit is high and hold until the next word-5 latch or word-0 latch.
- i_rx_abort in HDR or WAIT_AUTH: next cycle pulse o_clear, increment o_cnt_rejected, go to IDLE. Abort has priority over a same-cycle valid word or auth input. Abort in IDLE is ignored.
- i_rx_start with valid while in HDR: the old header is rejected (o_clear pulse, o_cnt_rejected + 1) and the new header starts (counter = 1, fields latched, record pulse). Clear and record may pulse in the same cycle.
- i_rx_start in WAIT_AUTH: ignored. Upstream must wait for !o_busy.
- Counters wrap modulo 2^32.
- Pulse exclusivity: at most one of o_transmit and o_clear is asserted per cycle.

Test Plan:
- Good v4 request: word0 = 64'h230006EC00000000, words 1-4 = 0, word5 = 64'hFFFFDDDD00000000, then i_auth_ok -> record pulse 1 cycle after word0; o_transmit with origin FFFFDDDD00000000, VN = 4, poll = 06; o_cnt_accepted = 1.
- Version 3 (word0 = 64'h1B0006EC...) -> accepted, VN = 3. Version 5 (word0 = 64'h2B...) -> o_clear right after word5 with no auth needed, o_cnt_rejected + 1, no o_transmit.
- Mode 4 (word0 = 64'h24...) -> rejected as above; i_auth_ok asserted afterwards produces no transmit.
- Abort after word 2 -> o_clear next cycle, o_busy = 0, o_cnt_rejected + 1; a following good header is accepted normally.
- Good header with i_auth_ok and i_auth_fail in the same cycle -> o_clear only, o_cnt_rejected + 1.
- Restart in HDR (new start at word 3) and assert i_areset mid-HDR -> restart gives clear + record in the same cycle; reset returns all outputs and counters to 0 with no pulses.
